pipelined_register_file: RTL

//   Parametrised register file for the MIPS pipeline: 2 async read ports, 1 sync write port.

---
 rtl/pipelined_register_file.sv | 86 ++++++++
 1 files changed

// File: rtl/pipelined_register_file.sv
// Pipeline register file: two combinational read ports, one synchronous write port,
// optional hardwired zero register, write-to-read bypass and a pending-write scoreboard.
module pipelined_register_file #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;

    logic              wr_to_zero;
    logic              rsv_to_zero;
    logic [ADDR_W-1:0] port_addr [2];
    logic [DATA_W-1:0] port_data [2];
    logic              port_busy [2];

    assign wr_to_zero  = ZERO_REG && (wr_addr == '0);
    assign rsv_to_zero = ZERO_REG && (rsv_addr == '0);

    // NOTE: the register array is cleared by reset because software relies on a known
    // post-reset state; this costs a reset mux per bit instead of a plain RAM macro.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            // NOTE: non-blocking assignments give every flop the pre-edge values; the
            // later assignment to the same pending bit wins, so a reservation overrides
            // a writeback clear on the same address.
            if (wr_en && !wr_to_zero) begin
                regs[wr_addr] <= wr_data;
            end
            if (wr_en) begin
                pending[wr_addr] <= 1'b0;
            end
            if (rsv_en && !rsv_to_zero) begin
                pending[rsv_addr] <= 1'b1;
            end
        end
    end

    assign port_addr[0] = rd_addr_1;
    assign port_addr[1] = rd_addr_2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: defaults first so every path assigns both outputs and no latch forms.
            port_data[p] = '0;
            port_busy[p] = 1'b0;
            if (ZERO_REG && (port_addr[p] == '0)) begin
                port_data[p] = '0;
            end else if (BYPASS && wr_en && (wr_addr == port_addr[p])) begin
                port_data[p] = wr_data;
            end else begin
                port_data[p] = regs[port_addr[p]];
                port_busy[p] = pending[port_addr[p]];
            end
        end
    end

    assign rd_data_1 = port_data[0];
    assign rd_data_2 = port_data[1];
    assign busy_1    = port_busy[0];
    assign busy_2    = port_busy[1];

endmodule
